// File: rtl/pwd_entry_ctrl.sv
// Password-entry sequencer between the PS/2 receiver and the lock/alarm outputs.
// Optional macro PWD_BACKSPACE_EN: make code 8'h66 deletes the last buffered code.
module pwd_entry_ctrl #(
  parameter int unsigned          PW_LEN      = 5,
  parameter logic [PW_LEN*8-1:0]  PASSWORD    = 40'h1D262E4D31,
  parameter int unsigned          MAX_FAIL    = 3,
  parameter int unsigned          LOCK_CYCLES = 50_000_000,
  parameter logic [7:0]           ENTER_CODE  = 8'h5A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic       correct,
  output logic [1:0] Alarma_Vent,
  output logic       key_tick,
  output logic [3:0] key_count,
  output logic       locked
);

  localparam int unsigned BW = PW_LEN * 8;
  localparam int unsigned TW = $clog2(LOCK_CYCLES + 1);
  localparam int unsigned FW = $clog2(MAX_FAIL + 1);

  localparam logic [7:0] EXT_CODE  = 8'hE0;
  localparam logic [7:0] BRK_CODE  = 8'hF0;
  localparam logic [7:0] BKSP_CODE = 8'h66;

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_BREAK, S_CHECK, S_GRANT, S_GRANT_BRK, S_DENY, S_LOCK
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic [FW-1:0]   fail_q, fail_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            correct_q, correct_d;
  logic [1:0]      alarm_q, alarm_d;
  logic            tick_q, tick_d;

  logic [BW+7:0]   shifted;
  logic [FW-1:0]   fail_inc;
  logic            match;
  logic            abort;

  assign shifted  = {buf_q, rx_data};
  assign fail_inc = (fail_q == FW'(MAX_FAIL)) ? fail_q : fail_q + FW'(1);
  assign match    = (cnt_q == 4'(PW_LEN)) && !ovf_q && (buf_q == PASSWORD);
  assign abort    = !en && (state_q inside {S_COLLECT, S_BREAK, S_GRANT, S_GRANT_BRK});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      buf_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      fail_q    <= '0;
      timer_q   <= '0;
      correct_q <= 1'b0;
      alarm_q   <= '0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      fail_q    <= fail_d;
      timer_q   <= timer_d;
      correct_q <= correct_d;
      alarm_q   <= alarm_d;
      tick_q    <= tick_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    fail_d    = fail_q;
    timer_d   = timer_q;
    correct_d = correct_q;
    alarm_d   = alarm_q;
    tick_d    = 1'b0;

    if (abort) begin
      state_d   = S_IDLE;
      buf_d     = '0;
      cnt_d     = '0;
      ovf_d     = 1'b0;
      correct_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (en) state_d = S_COLLECT;

        S_COLLECT: if (rx_done_tick) begin
          if (rx_data == EXT_CODE) begin
            state_d = S_COLLECT;
          end else if (rx_data == BRK_CODE) begin
            state_d = S_BREAK;
          end else if (rx_data == ENTER_CODE) begin
            state_d = S_CHECK;
`ifdef PWD_BACKSPACE_EN
          end else if (rx_data == BKSP_CODE) begin
            // An overflowed entry only drops the overflow; the kept codes stay.
            if (ovf_q) begin
              ovf_d = 1'b0;
            end else if (cnt_q != '0) begin
              cnt_d = cnt_q - 4'd1;
              buf_d = buf_q >> 8;
            end
`endif
          end else begin
            if (cnt_q < 4'(PW_LEN)) begin
              buf_d = shifted[BW-1:0];
              cnt_d = cnt_q + 4'd1;
            end else begin
              ovf_d = 1'b1;
            end
            tick_d = 1'b1;
          end
        end

        S_BREAK: if (rx_done_tick) state_d = S_COLLECT;

        S_CHECK: begin
          if (match) begin
            state_d   = S_GRANT;
            correct_d = 1'b1;
            fail_d    = '0;
            alarm_d   = 2'b00;
          end else begin
            state_d = S_DENY;
          end
        end

        S_DENY: begin
          fail_d = fail_inc;
          buf_d  = '0;
          cnt_d  = '0;
          ovf_d  = 1'b0;
          if (fail_inc == FW'(MAX_FAIL)) begin
            state_d = S_LOCK;
            timer_d = TW'(LOCK_CYCLES - 1);
            alarm_d = 2'b10;
          end else begin
            state_d = S_COLLECT;
            alarm_d = 2'b01;
          end
        end

        // Break prefix while granted must swallow the released key, not restart.
        S_GRANT: if (rx_done_tick) begin
          if (rx_data == BRK_CODE) begin
            state_d = S_GRANT_BRK;
          end else if (rx_data != EXT_CODE && rx_data != ENTER_CODE) begin
            state_d    = S_COLLECT;
            buf_d      = '0;
            buf_d[7:0] = rx_data;
            cnt_d      = 4'd1;
            ovf_d      = 1'b0;
            correct_d  = 1'b0;
            tick_d     = 1'b1;
          end
        end

        S_GRANT_BRK: if (rx_done_tick) state_d = S_GRANT;

        S_LOCK: begin
          if (timer_q == '0) begin
            state_d = S_IDLE;
            fail_d  = '0;
            alarm_d = 2'b00;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  assign correct     = correct_q;
  assign Alarma_Vent = alarm_q;
  assign key_tick    = tick_q;
  assign key_count   = cnt_q;
  assign locked      = (state_q == S_LOCK);

endmodule

// File: tb/tb_pwd_entry_ctrl.sv
// Self-checking bench for pwd_entry_ctrl against a queue-based entry model.
module tb_pwd_entry_ctrl;
  localparam int PW_LEN = 5;
  localparam int MAXF   = 3;
  localparam int LOCKN  = 1000;
  localparam logic [7:0] ENTER = 8'h5A;

  logic       clk = 1'b0;
  logic       rst, en, rx_done_tick;
  logic [7:0] rx_data;
  logic       correct, key_tick, locked;
  logic [1:0] Alarma_Vent;
  logic [3:0] key_count;

  always #5 clk = ~clk;

  pwd_entry_ctrl #(
    .PW_LEN(5), .PASSWORD(40'h1D262E4D31), .MAX_FAIL(3),
    .LOCK_CYCLES(LOCKN), .ENTER_CODE(8'h5A)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .correct(correct), .Alarma_Vent(Alarma_Vent), .key_tick(key_tick),
    .key_count(key_count), .locked(locked)
  );

  int checks = 0;
  int errors = 0;
  int ticks = 0;
  int lock_neg = 0;
  always @(negedge clk) begin
    if (key_tick === 1'b1) ticks++;
    if (locked === 1'b1) lock_neg++;
  end

  logic [7:0] obs;
  assign obs = {correct, Alarma_Vent, key_count, locked};

  // Reference model: the entry is a queue of make codes plus a few flags.
  logic [7:0] pw[5] = '{8'h1D, 8'h26, 8'h2E, 8'h4D, 8'h31};
  logic [7:0] m_q[$];
  bit m_ovf, m_brk, m_active, m_granted, m_locked, m_en;
  int m_fail, m_alarm, m_ticks;

  function automatic logic [7:0] m_vec();
    logic [1:0] a = 2'(m_alarm);
    logic [3:0] k = 4'(m_q.size());
    return {m_granted, a, k, m_locked};
  endfunction

  function automatic bit m_match();
    if (m_q.size() != PW_LEN || m_ovf) return 1'b0;
    for (int i = 0; i < PW_LEN; i++) if (m_q[i] != pw[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    if (m_locked || !m_active) return;
    if (m_brk) begin m_brk = 0; return; end
    if (b == 8'hE0) return;
    if (b == 8'hF0) begin m_brk = 1; return; end
    if (m_granted) begin
      if (b != ENTER) begin
        m_granted = 0; m_q.delete(); m_q.push_back(b); m_ovf = 0; m_ticks++;
      end
      return;
    end
    if (b == ENTER) begin
      if (m_match()) begin
        m_granted = 1; m_fail = 0; m_alarm = 0;
      end else begin
        m_fail++; m_q.delete(); m_ovf = 0;
        if (m_fail >= MAXF) begin m_locked = 1; m_alarm = 2; end
        else m_alarm = 1;
      end
      return;
    end
`ifdef PWD_BACKSPACE_EN
    if (b == 8'h66) begin
      if (m_ovf) m_ovf = 0;
      else if (m_q.size() > 0) void'(m_q.pop_back());
      return;
    end
`endif
    if (m_q.size() < PW_LEN) m_q.push_back(b); else m_ovf = 1;
    m_ticks++;
  endtask

  task automatic model_clear();
    m_q.delete(); m_ovf = 0; m_brk = 0; m_granted = 0; m_locked = 0;
    m_fail = 0; m_alarm = 0; m_active = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); rx_data = b; rx_done_tick = 1'b1;
    @(negedge clk); rx_done_tick = 1'b0; rx_data = 8'($urandom);
    repeat (3) @(negedge clk);
    model_byte(b);
  endtask

  task automatic send_pw(input bit with_breaks);
    for (int i = 0; i < PW_LEN; i++) begin
      send_byte(pw[i]);
      if (with_breaks) begin send_byte(8'hF0); send_byte(pw[i]); end
    end
  endtask

  task automatic set_en(input logic v);
    @(negedge clk); en = v; m_en = v;
    if (!m_locked) begin
      if (!v) begin m_active = 0; m_brk = 0; m_granted = 0; m_q.delete(); m_ovf = 0; end
      else m_active = 1;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; rx_done_tick = 1'b0; rx_data = 8'h00; m_en = 0;
    model_clear(); m_ticks = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({obs, key_tick} !== 9'h000) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", {obs, key_tick}, 9'h000);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== m_vec()) begin errors++; $display("FAIL reset_release: got %h expected %h", obs, m_vec()); end
  endtask

  task automatic test_accept();
    int base;
    set_en(1'b1);
    base = ticks;
    send_pw(1'b1);
    @(negedge clk); rx_data = ENTER; rx_done_tick = 1'b1;
    @(negedge clk); rx_done_tick = 1'b0;
    checks++;
    if (correct !== 1'b0) begin errors++; $display("FAIL accept_check_cycle: got %b expected 0", correct); end
    @(negedge clk);
    checks++;
    if (correct !== 1'b1) begin errors++; $display("FAIL accept_latency: got %b expected 1", correct); end
    repeat (2) @(negedge clk);
    model_byte(ENTER);
    send_byte(8'hF0); send_byte(ENTER);
    checks++;
    if (obs !== m_vec() || obs[7:5] !== 3'b100) begin
      errors++; $display("FAIL accept_state: got %h expected %h", obs, m_vec());
    end
    checks++;
    if (ticks - base !== 5) begin errors++; $display("FAIL accept_ticks: got %0d expected 5", ticks - base); end
  endtask

  task automatic test_wrong_then_right();
    logic [7:0] s[6] = '{8'h1D, 8'h26, 8'h2E, 8'h4D, 8'h1D, 8'h5A};
    foreach (s[i]) send_byte(s[i]);
    checks++;
    if (obs !== m_vec() || obs !== 8'b0_01_0000_0) begin
      errors++; $display("FAIL wrong_deny: got %h expected %h", obs, 8'b0_01_0000_0);
    end
    send_pw(1'b0); send_byte(ENTER);
    checks++;
    if (obs !== m_vec() || obs[7:5] !== 3'b100) begin
      errors++; $display("FAIL right_after_wrong: got %h expected %h", obs, m_vec());
    end
  endtask

  task automatic test_overflow();
    int base = ticks;
    send_pw(1'b0); send_byte(8'h31); send_byte(ENTER);
    checks++;
    if (obs !== m_vec() || obs !== 8'b0_01_0000_0) begin
      errors++; $display("FAIL overflow_deny: got %h expected %h", obs, 8'b0_01_0000_0);
    end
    checks++;
    if (ticks - base !== 6) begin errors++; $display("FAIL overflow_ticks: got %0d expected 6", ticks - base); end
  endtask

  task automatic test_en_abort();
    send_byte(8'h1D); send_byte(8'h26); send_byte(8'h2E);
    set_en(1'b0);
    checks++;
    if (obs !== m_vec() || key_count !== 4'd0) begin
      errors++; $display("FAIL abort_clear: got %h expected %h", obs, m_vec());
    end
    set_en(1'b1);
    send_pw(1'b0); send_byte(ENTER);
    checks++;
    if (obs !== m_vec() || correct !== 1'b1) begin
      errors++; $display("FAIL abort_reentry: got %h expected %h", obs, m_vec());
    end
  endtask

  task automatic test_lockout();
    int base, lbase;
    send_byte(8'h1D); send_byte(ENTER);
    send_byte(8'h26); send_byte(ENTER);
    lbase = lock_neg;
    send_byte(ENTER);                     // empty entry counts as a failure
    checks++;
    if (obs !== m_vec() || obs !== 8'b0_10_0000_1) begin
      errors++; $display("FAIL lock_enter: got %h expected %h", obs, 8'b0_10_0000_1);
    end
    base = ticks;
    send_byte(8'h1D); send_byte(8'h26); send_byte(ENTER);
    checks++;
    if (ticks - base !== 0) begin errors++; $display("FAIL lock_ticks: got %0d expected 0", ticks - base); end
    for (int i = 0; i < 2 * LOCKN && locked !== 1'b0; i++) @(negedge clk);
    checks++;
    if (lock_neg - lbase !== LOCKN) begin
      errors++; $display("FAIL lock_duration: got %0d expected %0d", lock_neg - lbase, LOCKN);
    end
    m_locked = 0; m_fail = 0; m_alarm = 0; m_active = m_en;
    checks++;
    if (obs !== m_vec() || obs !== 8'h00) begin
      errors++; $display("FAIL lock_exit: got %h expected %h", obs, 8'h00);
    end
    repeat (2) @(negedge clk);
    send_byte(8'h1D); send_byte(ENTER);
    checks++;
    if (obs !== m_vec() || obs !== 8'b0_01_0000_0) begin
      errors++; $display("FAIL lock_fail_cleared: got %h expected %h", obs, 8'b0_01_0000_0);
    end
  endtask

  task automatic test_backspace();
    logic [7:0] s[8] = '{8'h1D, 8'h26, 8'h44, 8'h66, 8'h2E, 8'h4D, 8'h31, 8'h5A};
    foreach (s[i]) send_byte(s[i]);
    checks++;
`ifdef PWD_BACKSPACE_EN
    if (obs !== m_vec() || correct !== 1'b1) begin
      errors++; $display("FAIL backspace_accept: got %h expected %h", obs, m_vec());
    end
`else
    if (obs !== m_vec() || obs[7:5] !== 3'b001) begin
      errors++; $display("FAIL backspace_plain_deny: got %h expected %h", obs, m_vec());
    end
`endif
  endtask

  task automatic test_random();
    logic [7:0] b;
    int r;
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 99);
      if (r < 6) begin
        set_en(1'b0); set_en(1'b1);
      end else if (r < 14) begin
        send_pw(1'b0); send_byte(ENTER);
      end else begin
        r = $urandom_range(0, 19);
        if (r < 6)       b = pw[$urandom_range(0, PW_LEN - 1)];
        else if (r < 8)  b = 8'hF0;
        else if (r < 9)  b = 8'hE0;
        else if (r < 11) b = ENTER;
        else if (r < 12) b = 8'h66;
        else             b = 8'($urandom_range(0, 255));
        send_byte(b);
      end
      checks++;
      if (obs !== m_vec()) begin errors++; $display("FAIL random_state[%0d]: got %h expected %h", n, obs, m_vec()); end
      checks++;
      if (ticks !== m_ticks) begin errors++; $display("FAIL random_ticks[%0d]: got %0d expected %0d", n, ticks, m_ticks); end
      if (m_locked) begin
        for (int i = 0; i < 2 * LOCKN && locked !== 1'b0; i++) @(negedge clk);
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL random_lock_release[%0d]: got %b expected 0", n, locked); end
        m_locked = 0; m_fail = 0; m_alarm = 0; m_active = m_en;
        repeat (2) @(negedge clk);
      end
    end
  endtask

  task automatic test_async_reset();
    set_en(1'b1);
    send_byte(8'h1D); send_byte(8'h26);
    checks++;
    if (obs !== m_vec() || key_count !== 4'd2) begin
      errors++; $display("FAIL pre_reset: got %h expected %h", obs, m_vec());
    end
    @(negedge clk); #2 rst = 1'b0; #1;
    checks++;
    if ({obs, key_tick} !== 9'h000) begin
      errors++; $display("FAIL async_reset: got %h expected %h", {obs, key_tick}, 9'h000);
    end
    @(negedge clk); rst = 1'b1;
    model_clear(); m_active = m_en;
    repeat (2) @(negedge clk);
    send_pw(1'b0); send_byte(ENTER);
    checks++;
    if (obs !== m_vec() || correct !== 1'b1) begin
      errors++; $display("FAIL post_reset_accept: got %h expected %h", obs, m_vec());
    end
  endtask

  initial begin
    test_reset();
    test_accept();
    test_wrong_then_right();
    test_overflow();
    test_en_abort();
    test_lockout();
    test_backspace();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
